// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// BOOTH_MULT_RADIX4_EN selects modified Booth radix-4 instead of radix-2.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Digit selected by one Booth step
    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_ADD_M,
        SEL_SUB_M,
        SEL_ADD_2M,
        SEL_SUB_2M
    } sel_t;

`ifdef BOOTH_MULT_RADIX4_EN
    localparam int STEP_SHIFT = 2;
`else
    localparam int STEP_SHIFT = 1;
`endif

    function automatic int nstep(input int b_w);
`ifdef BOOTH_MULT_RADIX4_EN
        return (b_w + 2) / 2;
`else
        return b_w + 1;
`endif
    endfunction

    // Accumulator carries a guard bit (two in radix-4 so that 2M fits)
    function automatic int acc_w(input int a_w);
        return a_w + STEP_SHIFT;
    endfunction

    function automatic int q_w(input int b_w);
        return STEP_SHIFT * nstep(b_w);
    endfunction

    function automatic sel_t booth_sel_r2(input logic [1:0] win);
        case (win)
            2'b10:   return SEL_SUB_M;
            2'b01:   return SEL_ADD_M;
            default: return SEL_ZERO;
        endcase
    endfunction

    function automatic sel_t booth_sel_r4(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: return SEL_ADD_M;
            3'b011:         return SEL_ADD_2M;
            3'b100:         return SEL_SUB_2M;
            3'b101, 3'b110: return SEL_SUB_M;
            default:        return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_step_r.sv
// One combinational Booth step: add/subtract the selected multiple of M,
// then arithmetic-shift {acc, Q, q_1}. Radix follows BOOTH_MULT_RADIX4_EN.
module booth_step_r
    import booth_pkg::*;
#(
    parameter int A_W = 25,
    parameter int B_W = 16
) (
    input  logic [acc_w(A_W)-1:0] acc_i,
    input  logic [q_w(B_W)-1:0]   q_i,
    input  logic                  q1_i,
    input  logic [acc_w(A_W)-1:0] m_i,
    output logic [acc_w(A_W)-1:0] acc_o,
    output logic [q_w(B_W)-1:0]   q_o,
    output logic                  q1_o
);
    localparam int ACC_W = acc_w(A_W);
    localparam int Q_W   = q_w(B_W);
    localparam int SUM_W = ACC_W + 1;
    localparam int CAT_W = SUM_W + Q_W;

    sel_t                    sel;
    logic signed [SUM_W-1:0] acc_x;
    logic signed [SUM_W-1:0] m_x;
    logic signed [SUM_W-1:0] addend;
    logic signed [SUM_W-1:0] sum;
    logic signed [CAT_W-1:0] cat;

    always_comb begin
`ifdef BOOTH_MULT_RADIX4_EN
        sel = booth_sel_r4({q_i[1:0], q1_i});
`else
        sel = booth_sel_r2({q_i[0], q1_i});
`endif
        acc_x  = {acc_i[ACC_W-1], acc_i};
        m_x    = {m_i[ACC_W-1], m_i};
        addend = '0;
        case (sel)
            SEL_ADD_M:  addend = m_x;
            SEL_SUB_M:  addend = -m_x;
            SEL_ADD_2M: addend = m_x <<< 1;
            SEL_SUB_2M: addend = -(m_x <<< 1);
            default:    addend = '0;
        endcase
        // One spare sum bit keeps the add exact before the shift discards it
        sum            = acc_x + addend;
        cat            = {sum, q_i};
        {acc_o, q_o}   = (ACC_W + Q_W)'(cat >>> STEP_SHIFT);
        q1_o           = q_i[STEP_SHIFT-1];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative Booth multiplier with valid/ready handshakes, one step per clock.
// Define BOOTH_MULT_RADIX4_EN for modified Booth radix-4 (fewer steps).
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int A_W = 25,
    parameter int B_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_signed,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [A_W+B_W-1:0] o_p,
    output logic             o_busy
);
    localparam int NSTEP = nstep(B_W);
    localparam int ACC_W = acc_w(A_W);
    localparam int Q_W   = q_w(B_W);
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(NSTEP + 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [Q_W-1:0]   q_q, q_d;
    logic             q1_q, q1_d;
    logic [ACC_W-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   p_q, p_d;

    logic [ACC_W-1:0] st_acc;
    logic [Q_W-1:0]   st_q;
    logic             st_q1;

    booth_step_r #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (st_acc),
        .q_o   (st_q),
        .q1_o  (st_q1)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    m_d     = {{(ACC_W - A_W){i_signed & i_a[A_W-1]}}, i_a};
                    q_d     = {{(Q_W - B_W){i_signed & i_b[B_W-1]}}, i_b};
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CNT_W'(NSTEP);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = st_acc;
                q_d   = st_q;
                q1_d  = st_q1;
                cnt_d = cnt_q - CNT_W'(1);
                // Last step: capture the product as DONE is entered
                if (cnt_q == CNT_W'(1)) begin
                    p_d     = P_W'({st_acc, st_q});
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == RUN);
    assign o_valid = (state_q == DONE);
    assign o_p     = p_q;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Iterative, parametrised Booth multiplier for the FIR/audio datapath. Successor to the single combinational Booth step.
- Holds accumulator, multiplier shift register and count internally; performs one Booth step per clock.
- Valid/ready handshake on input and output. Selectable signed or unsigned operands.
- Exact full-width product. The accumulator carries a guard bit, so the most-negative-operand case does not overflow.

Parameters:
A_W, 25, multiplicand width (bits)
B_W, 16, multiplier width (bits)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  operand pair valid
o_ready  out  1  block can accept operands
i_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
i_a  in  A_W  multiplicand
i_b  in  B_W  multiplier
o_valid  out  1  product valid
i_ready  in  1  downstream accepts product
o_p  out  A_W+B_W  product
o_busy  out  1  high in RUN

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_p=0, all internal registers 0.
- Reset asserted mid-operation aborts the operation immediately; nothing is emitted afterwards.
- States:
  - IDLE: o_ready=1. i_valid&&o_ready at edge E0 → load and go to RUN.
  - RUN: one step per edge. The edge performing the last step → DONE.
  - DONE: o_valid=1 and o_p stable. i_ready at an edge → IDLE.
- No accept in RUN or DONE. o_ready is 1 only in IDLE.
- Load at E0:
  - M = i_a extended to A_W+1 bits (sign-extended if i_signed, else zero-extended).
  - Q = i_b extended to B_W+1 bits the same way.
  - Accumulator = 0 (A_W+1 bits); q_1 = 0; count = NSTEP.
- Step rule, on {Q[0], q_1}:
  - 10 → acc − M.
  - 01 → acc + M.
  - 00 or 11 → acc unchanged.
  - Then arithmetic right shift of {acc, Q, q_1} by 1, computed at A_W+1 bits.
- Radix-2: NSTEP = B_W+1. o_valid is first high in the cycle after edge E0+NSTEP, so latency = B_W+1 cycles after the accept edge.
- Result: {acc, Q} is an A_W+B_W+2-bit signed value. o_p = its low A_W+B_W bits, which is exact for both modes.
- o_p is registered on entry to DONE and held until the handshake. It keeps its last value in IDLE.
- Back-to-back operations: the earliest next accept is the edge after the DONE handshake. Throughput = one result per NSTEP+2 cycles.
- i_valid with operand changes outside IDLE is ignored. i_signed is used only as latched at E0.
- i_ready held low keeps DONE indefinitely; o_p does not change.

Optional Feature:
- Macro BOOTH_MULT_RADIX4_EN.
- Defined: modified Booth radix-4.
  - Multiplier extended to 2*NSTEP bits, NSTEP = (B_W+2)/2 (9 for B_W=16).
  - Each step examines {Q[1:0], q_1} and selects 0, ±M or ±2M.
  - Accumulator is A_W+2 bits; arithmetic shift by 2 per step.
  - Handshake and result are identical; only latency changes.
- Undefined: radix-2 as above, NSTEP = B_W+1.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - function nstep(B_W) covering both radix modes.
  - Booth encoding constants (digit select codes).
- Sub-module booth_step_r: parametrised combinational step taking acc, Q, q_1, M and producing the shifted acc, Q, q_1. Radix set by the same macro.
- FSM, counter and handshake live in booth_mult_seq.

Test Plan (A_W=25, B_W=16):
1. Signed: a=3, b=−2 (0xFFFE) accepted at E0 → o_valid first high exactly 17 cycles later, o_p = −6 (0x1FFFFFFFFFA, 41 bits).
2. Signed extremes: a=0x1000000 (−2^24), b=0x8000 (−2^15) → o_p = 0x08000000000 (+2^39), no overflow.
3. Unsigned: a=0x1FFFFFF, b=0xFFFF, i_signed=0 → o_p = 0x1FFFDFF0001. Same operands with i_signed=1 → o_p = +1.
4. Backpressure: i_ready low for 5 cycles in DONE → o_p and o_valid stable, o_ready=0, a new i_valid is ignored. Release → IDLE next cycle, next operand accepted the following edge.
5. Reset mid-RUN after 8 steps → outputs at reset values immediately. A fresh 7×9 op afterwards gives o_p = 63 with normal latency.
6. With BOOTH_MULT_RADIX4_EN defined: cases 1–3 give identical products, latency 9 cycles.
